// File: rtl/blink_pkg.sv
// Shared state encoding and default parameter values for the blink pattern generator.
package blink_pkg;

   localparam int DEF_PRESCALE  = 12000;
   localparam int DEF_PAT_W     = 8;
   localparam int DEF_GAP_TICKS = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      GAP  = 2'd2
   } state_t;

endpackage

// File: rtl/blink_prescaler.sv
// Free-running bit-period counter; tick is high for the cycle where the count sits at PRESCALE-1.
module blink_prescaler
   import blink_pkg::*;
#(
   parameter int PRESCALE = DEF_PRESCALE
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   output logic tick
);

   localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

   logic [CW-1:0] count;

   assign tick = (count == CW'(PRESCALE - 1));

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         count <= '0;
      end else if (tick) begin
         count <= '0;
      end else begin
         count <= count + CW'(1);
      end
   end

endmodule

// File: rtl/blink_pattern_gen.sv
// Serial LED pattern player: loads a PAT_W-bit pattern and plays it LSB first, PRESCALE clocks per bit.
// Define BLINK_REPEAT_EN to loop the pattern with a GAP_TICKS-bit low gap instead of a one-shot with done.
module blink_pattern_gen
   import blink_pkg::*;
#(
   parameter int PRESCALE  = DEF_PRESCALE,
   parameter int PAT_W     = DEF_PAT_W,
   parameter int GAP_TICKS = DEF_GAP_TICKS
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [PAT_W-1:0] pat_data,
   input  logic             load_valid,
   output logic             load_ready,
   input  logic             stop,
   output logic             led,
   output logic             busy,
   output logic             done
);

   localparam int IDX_W = $clog2(PAT_W);

   if (PRESCALE < 1 || PAT_W < 2 || GAP_TICKS < 1) begin : g_bad_param
      $error("blink_pattern_gen: PRESCALE>=1, PAT_W>=2 and GAP_TICKS>=1 are required");
   end

   state_t           state, state_nxt;
   logic [PAT_W-1:0] pat, pat_nxt;
   logic [IDX_W-1:0] idx, idx_nxt;
   logic             led_nxt, busy_nxt, done_nxt;
   logic             tick, pat_last;

`ifdef BLINK_REPEAT_EN
   localparam int GAP_W = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;
   logic [GAP_W-1:0] gap_cnt, gap_nxt;
   logic             gap_last;
   assign gap_last = (gap_cnt == GAP_W'(GAP_TICKS - 1));
`endif

   // Prescaler is held cleared in IDLE so the first bit after a load gets a full period.
   blink_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
      .clk  (clk),
      .rst  (rst),
      .clr  (state == IDLE),
      .tick (tick)
   );

   assign pat_last   = (idx == IDX_W'(PAT_W - 1));
   assign load_ready = (state == IDLE);

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         pat     <= '0;
         idx     <= '0;
         led     <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
`ifdef BLINK_REPEAT_EN
         gap_cnt <= '0;
`endif
      end else begin
         state   <= state_nxt;
         pat     <= pat_nxt;
         idx     <= idx_nxt;
         led     <= led_nxt;
         busy    <= busy_nxt;
         done    <= done_nxt;
`ifdef BLINK_REPEAT_EN
         gap_cnt <= gap_nxt;
`endif
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (load_valid) state_nxt = RUN;
         RUN: begin
            if (stop) begin
               state_nxt = IDLE;
            end else if (tick && pat_last) begin
`ifdef BLINK_REPEAT_EN
               state_nxt = GAP;
`else
               state_nxt = IDLE;
`endif
            end
         end
`ifdef BLINK_REPEAT_EN
         GAP: begin
            if (stop) begin
               state_nxt = IDLE;
            end else if (tick && gap_last) begin
               state_nxt = RUN;
            end
         end
`endif
         default: state_nxt = IDLE;
      endcase
   end

   // Next values of the registered outputs and datapath; stop outranks a coincident tick.
   always_comb begin
      pat_nxt  = pat;
      idx_nxt  = idx;
      led_nxt  = led;
      done_nxt = 1'b0;
      busy_nxt = (state_nxt != IDLE);
`ifdef BLINK_REPEAT_EN
      gap_nxt  = gap_cnt;
`endif
      case (state)
         IDLE: begin
            led_nxt = 1'b0;
            if (load_valid) begin
               pat_nxt = pat_data;
               idx_nxt = '0;
               led_nxt = pat_data[0];
            end
         end
         RUN: begin
            if (stop) begin
               led_nxt = 1'b0;
               idx_nxt = '0;
            end else if (tick) begin
               if (pat_last) begin
                  led_nxt = 1'b0;
                  idx_nxt = '0;
`ifdef BLINK_REPEAT_EN
                  gap_nxt = '0;
`else
                  done_nxt = 1'b1;
`endif
               end else begin
                  idx_nxt = idx + IDX_W'(1);
                  led_nxt = pat[idx_nxt];
               end
            end
         end
`ifdef BLINK_REPEAT_EN
         GAP: begin
            led_nxt = 1'b0;
            if (stop) begin
               gap_nxt = '0;
            end else if (tick) begin
               if (gap_last) begin
                  gap_nxt = '0;
                  idx_nxt = '0;
                  led_nxt = pat[0];
               end else begin
                  gap_nxt = gap_cnt + GAP_W'(1);
               end
            end
         end
`endif
         default: begin
            led_nxt = 1'b0;
            idx_nxt = '0;
         end
      endcase
   end

endmodule

// File: tb/tb_blink_pattern_gen.sv
// Bench for blink_pattern_gen: two instances (PRESCALE=4/PAT_W=4 and PRESCALE=1/PAT_W=2) against a timeline model.
module tb_blink_pattern_gen;

   logic       clk = 1'b0;
   logic [1:0] rst_v = 2'b11;
   logic [1:0] load_v = 2'b00;
   logic [1:0] stop_v = 2'b00;
   logic [3:0] pat_a = 4'd0;
   logic [1:0] pat_b = 2'd0;
   logic [1:0] led_v, busy_v, done_v, rdy_v;

   always #5 clk = ~clk;

   blink_pattern_gen #(.PRESCALE(4), .PAT_W(4), .GAP_TICKS(2)) dut_a (
      .clk        (clk),
      .rst        (rst_v[0]),
      .pat_data   (pat_a),
      .load_valid (load_v[0]),
      .load_ready (rdy_v[0]),
      .stop       (stop_v[0]),
      .led        (led_v[0]),
      .busy       (busy_v[0]),
      .done       (done_v[0])
   );

   blink_pattern_gen #(.PRESCALE(1), .PAT_W(2), .GAP_TICKS(1)) dut_b (
      .clk        (clk),
      .rst        (rst_v[1]),
      .pat_data   (pat_b),
      .load_valid (load_v[1]),
      .load_ready (rdy_v[1]),
      .stop       (stop_v[1]),
      .led        (led_v[1]),
      .busy       (busy_v[1]),
      .done       (done_v[1])
   );

   // Model: a playback is a timeline t counted in clocks since load; led = pattern[t / PRESCALE].
   int         prm_p [2] = '{4, 1};
   int         prm_w [2] = '{4, 2};
   int         prm_g [2] = '{2, 1};
   bit         m_act [2];
   bit         m_done[2];
   int         m_t   [2];
   logic [3:0] m_pat [2];

   always @(posedge clk) begin
      for (int k = 0; k < 2; k++) begin
         m_done[k] = 1'b0;
         if (rst_v[k]) begin
            m_act[k] = 1'b0;
         end else if (!m_act[k]) begin
            if (load_v[k]) begin
               m_act[k] = 1'b1;
               m_t[k]   = 0;
               m_pat[k] = (k == 0) ? pat_a : {2'b00, pat_b};
            end
         end else if (stop_v[k]) begin
            m_act[k] = 1'b0;
         end else begin
            m_t[k] = m_t[k] + 1;
`ifdef BLINK_REPEAT_EN
            if (m_t[k] == prm_p[k] * (prm_w[k] + prm_g[k])) m_t[k] = 0;
`else
            if (m_t[k] == prm_p[k] * prm_w[k]) begin
               m_act[k]  = 1'b0;
               m_done[k] = 1'b1;
            end
`endif
         end
      end
   end

   int  errors = 0;
   int  checks = 0;
   bit  chk_en = 1'b0;
   logic [63:0] seq_led, seq_done, seq_rdy, seq_busy;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Advance to the next falling edge and compare every output of both instances with the model.
   task automatic step();
      logic e_led;
      @(negedge clk);
      if (chk_en) begin
         for (int k = 0; k < 2; k++) begin
            e_led = 1'b0;
            if (m_act[k] && (m_t[k] < prm_p[k] * prm_w[k])) e_led = m_pat[k][m_t[k] / prm_p[k]];
            chk($sformatf("model_led[%0d]", k),  64'(led_v[k]),  64'(e_led));
            chk($sformatf("model_busy[%0d]", k), 64'(busy_v[k]), 64'(m_act[k]));
            chk($sformatf("model_done[%0d]", k), 64'(done_v[k]), 64'(m_done[k]));
            chk($sformatf("model_ready[%0d]", k), 64'(rdy_v[k]), 64'(!m_act[k]));
         end
      end
   endtask

   task automatic halt();
      stop_v = 2'b11;
      step();
      stop_v = 2'b00;
      step();
   endtask

   task automatic load_a(input logic [3:0] p);
      pat_a  = p;
      load_v = 2'b01;
      step();
      load_v = 2'b00;
   endtask

   initial begin
      repeat (3) @(negedge clk);
      rst_v  = 2'b00;
      chk_en = 1'b1;
      step();
      chk("reset_led",   64'(led_v),  64'(2'b00));
      chk("reset_busy",  64'(busy_v), 64'(2'b00));
      chk("reset_done",  64'(done_v), 64'(2'b00));
      chk("reset_ready", 64'(rdy_v),  64'(2'b11));

`ifdef BLINK_REPEAT_EN
      // 0110 with 2 gap ticks: 16 pattern clocks, 8 low, then restart
      load_a(4'b0110);
      seq_led = '0; seq_done = '0;
      for (int i = 0; i < 36; i++) begin
         seq_led[i] = led_v[0]; seq_done[i] = done_v[0];
         step();
      end
      chk("repeat_led",  seq_led,  64'h0000_000F_F000_0FF0);
      chk("repeat_done", seq_done, 64'h0);
`else
      load_a(4'b1011);
      seq_led = '0; seq_done = '0; seq_rdy = '0;
      for (int i = 0; i < 20; i++) begin
         seq_led[i] = led_v[0]; seq_done[i] = done_v[0]; seq_rdy[i] = rdy_v[0];
         step();
      end
      chk("oneshot_led",   seq_led,  64'h0F0FF);
      chk("oneshot_done",  seq_done, 64'h10000);
      chk("oneshot_ready", seq_rdy,  64'hF0000);
`endif
      halt();

      // PRESCALE=1, two-bit pattern 2'b10
      pat_b  = 2'b10;
      load_v = 2'b10;
      step();
      load_v = 2'b00;
      seq_led = '0; seq_done = '0;
      for (int i = 0; i < 5; i++) begin
         seq_led[i] = led_v[1]; seq_done[i] = done_v[1];
         step();
      end
`ifdef BLINK_REPEAT_EN
      chk("fast_led",  seq_led,  64'b10010);
      chk("fast_done", seq_done, 64'b00000);
`else
      chk("fast_led",  seq_led,  64'b00010);
      chk("fast_done", seq_done, 64'b00100);
`endif
      halt();

      // load_valid held with different data during playback
      load_a(4'b1011);
      load_v = 2'b01;
      pat_a  = 4'b0100;
      seq_led = '0; seq_rdy = '0;
      for (int i = 0; i < 16; i++) begin
         seq_led[i] = led_v[0]; seq_rdy[i] = rdy_v[0];
         if (i == 13) load_v = 2'b00;
         step();
      end
      chk("hold_load_led",   seq_led, 64'hF0FF);
      chk("hold_load_ready", seq_rdy, 64'h0);
      halt();

      // stop lands on the same edge as the tick leaving index 2
      load_a(4'b0100);
      seq_led = '0; seq_done = '0; seq_busy = '0;
      for (int i = 0; i < 14; i++) begin
         seq_led[i] = led_v[0]; seq_done[i] = done_v[0]; seq_busy[i] = busy_v[0];
         if (i == 11) stop_v = 2'b01;
         if (i == 12) stop_v = 2'b00;
         step();
      end
      chk("stop_tick_led",  seq_led,  64'h0F00);
      chk("stop_tick_done", seq_done, 64'h0);
      chk("stop_tick_busy", seq_busy, 64'h0FFF);

      // load and stop together in IDLE: load wins
      pat_a  = 4'b0001;
      load_v = 2'b01;
      stop_v = 2'b01;
      step();
      load_v = 2'b00;
      stop_v = 2'b00;
      chk("load_with_stop_busy", 64'(busy_v[0]), 64'(1'b1));
      chk("load_with_stop_led",  64'(led_v[0]),  64'(1'b1));
      halt();

      // reset held three cycles in the middle of a pattern
      load_a(4'b1111);
      repeat (5) step();
      rst_v = 2'b01;
      repeat (3) step();
      rst_v = 2'b00;
      chk("midrun_reset_led",   64'(led_v[0]),  64'(1'b0));
      chk("midrun_reset_busy",  64'(busy_v[0]), 64'(1'b0));
      chk("midrun_reset_done",  64'(done_v[0]), 64'(1'b0));
      chk("midrun_reset_ready", 64'(rdy_v[0]),  64'(1'b1));
      step();

      // randomized traffic on both instances
      for (int n = 0; n < 4000; n++) begin
         for (int k = 0; k < 2; k++) begin
            rst_v[k]  = ($urandom_range(0, 149) == 0);
            load_v[k] = ($urandom_range(0, 3) == 0);
            stop_v[k] = ($urandom_range(0, 63) == 0);
         end
         pat_a = 4'($urandom);
         pat_b = 2'($urandom);
         step();
      end
      rst_v  = 2'b00;
      load_v = 2'b00;
      stop_v = 2'b00;
      step();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/blink_pattern_gen.md
BLINK_PATTERN_GEN -- requirements
Module: blink_pattern_gen

Interface
REQ-001 SHALL have parameter PRESCALE, default 12000, clk cycles per pattern bit (>=1).
REQ-002 SHALL have parameter PAT_W, default 8, pattern length in bits (>=2).
REQ-003 SHALL have parameter GAP_TICKS, default 4, bit periods of forced-low gap between repeats (>=1).
REQ-004 SHALL have port clk  input  1  sole clock; rising edge active.
REQ-005 SHALL have port rst  input  1  reset; one clock; reset is synchronous and active-high.
REQ-006 SHALL have port pat_data  input  PAT_W  pattern to play, bit 0 first.
REQ-007 SHALL have port load_valid  input  1  pattern-load request.
REQ-008 SHALL have port load_ready  output  1  high only in IDLE.
REQ-009 SHALL have port stop  input  1  abort playback.
REQ-010 SHALL have port led  output  1  serial pattern drive (registered).
REQ-011 SHALL have port busy  output  1  high in RUN or GAP.
REQ-012 SHALL have port done  output  1  one-cycle pulse on one-shot completion.

Function
REQ-013 SHALL implement FSM states IDLE, RUN, GAP; all outputs registered except load_ready (decoded from state).
REQ-014 SHALL accept a load on a clk edge where load_valid and load_ready are both high, capturing pat_data into an internal shift register.
REQ-015 SHALL, on the cycle after acceptance, be in RUN with led = pat_data[0], bit index 0, prescaler cleared.
REQ-016 SHALL generate tick for one cycle when prescaler count equals PRESCALE-1, then wrap to 0; PRESCALE=1 ticks every cycle.
REQ-017 SHALL hold each bit on led for exactly PRESCALE cycles; on tick advance index and drive next bit.
REQ-018 SHALL, on tick at index PAT_W-1, take the end-of-pattern action per REQ-026/REQ-027.
REQ-019 SHALL hold led low throughout GAP and return to RUN with index 0 after GAP_TICKS ticks.
REQ-020 SHALL on stop high in RUN or GAP go to IDLE next cycle, led=0, no done pulse; stop wins over a simultaneous tick.
REQ-021 SHALL ignore stop in IDLE; load_valid and stop together in IDLE accept the load.
REQ-022 SHALL ignore load_valid outside IDLE; pattern register is not modified during playback.

Reset
REQ-023 SHALL on rst high at a clk edge enter IDLE, clearing prescaler, index, gap counter and pattern register.
REQ-024 SHALL reset outputs to led=0, busy=0, done=0; load_ready=1 from the first cycle after reset.
REQ-025 SHALL give rst priority over load_valid, stop and tick, including mid-pattern.

Configuration
REQ-026 SHALL, with macro BLINK_REPEAT_EN defined, go RUN->GAP at pattern end and loop indefinitely until stop or rst; done never pulses.
REQ-027 SHALL, without BLINK_REPEAT_EN, go RUN->IDLE at pattern end, led=0, pulsing done for exactly one cycle on entry to IDLE; GAP state and gap counter are compiled out.

Structure
REQ-028 SHALL place the state enum (IDLE, RUN, GAP) and default parameter constants in shared package blink_pkg.
REQ-029 SHALL implement the tick counter as sub-module blink_prescaler (ports clk, rst, clr, tick; parameter PRESCALE).

Verification
REQ-030 SHALL cover reset: rst held 3 cycles mid-RUN -> next cycle led=0, busy=0, done=0, load_ready=1.
REQ-031 SHALL cover one-shot (no macro, PRESCALE=4, PAT_W=4): load 4'b1011 -> led 1,1,0,1 each for 4 cycles, then led=0, done high exactly 1 cycle, load_ready=1.
REQ-032 SHALL cover repeat (BLINK_REPEAT_EN, PRESCALE=4, PAT_W=4, GAP_TICKS=2): load 4'b0110 -> 16 cycles of 0,1,1,0 pattern, 8 cycles low, pattern restarts; done stays 0.
REQ-033 SHALL cover stop colliding with tick at index 2 -> IDLE next cycle, led=0, no done pulse.
REQ-034 SHALL cover load_valid held high during RUN with differing pat_data -> pattern unchanged, load_ready=0 until IDLE.
REQ-035 SHALL cover PRESCALE=1, PAT_W=2, pat_data=2'b10 -> led 0 then 1 for one cycle each, then done.
